// File: rtl/fact_ctrl.sv
// Moore controller for the iterative 32-bit factorial datapath.
// Sequences load, range check and the multiply loop, then reports Done or Error.
module fact_ctrl #(
  parameter int unsigned ITER_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Go,
  input  logic              GT12,
  input  logic              GT1,
  output logic              Ld_CNT,
  output logic              EN,
  output logic              Sel,
  output logic              LdR,
  output logic              OE,
  output logic              Done,
  output logic              Error,
  output logic [ITER_W-1:0] ITER,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StMult  = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } state_e;

  // Plain vector so the unused codes 6 and 7 remain representable.
  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  always_comb begin
    state_d = StIdle;
    iter_d  = iter_q;
    case (state_q)
      StIdle:  state_d = Go ? StLoad : StIdle;
      StLoad: begin
        state_d = StCheck;
        iter_d  = '0;
      end
      StCheck: begin
        if (GT12)     state_d = StErr;
        else if (GT1) state_d = StMult;
        else          state_d = StDone;
      end
      StMult: begin
        state_d = StCheck;
        if (iter_q != '1) iter_d = iter_q + ITER_W'(1);
      end
      StDone:  state_d = Go ? StDone : StIdle;
      StErr:   state_d = Go ? StErr : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Outputs depend on the state register only.
  always_comb begin
    Ld_CNT = 1'b0;
    EN     = 1'b0;
    Sel    = 1'b0;
    LdR    = 1'b0;
    OE     = 1'b0;
    Done   = 1'b0;
    Error  = 1'b0;
    case (state_q)
      StLoad: begin
        Ld_CNT = 1'b1;
        EN     = 1'b1;
        Sel    = 1'b1;
        LdR    = 1'b1;
      end
      StMult: begin
        EN  = 1'b1;
        LdR = 1'b1;
      end
      StDone: begin
        OE   = 1'b1;
        Done = 1'b1;
      end
      StErr:   Error = 1'b1;
      default: ;
    endcase
  end

  assign ITER  = iter_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl: a behavioural factorial datapath closes the loop, a vector
// table drives runs and a scoreboard queue holds the expected outcome of each run.
module tb_fact_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Go  = 1'b0;
  logic       GT12, GT1;
  logic       Ld_CNT, EN, Sel, LdR, OE, Done, Error;
  logic [4:0] ITER;
  logic [2:0] STATE;

  int unsigned n = 0;
  logic [31:0] cnt_q = '0;
  logic [31:0] reg_q = '0;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned n;
    bit          pulse;
    bit          exp_err;
    int unsigned exp_iter;
    longint      exp_result;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];
  vec_t sb_q[$];

  always #5 CLK = ~CLK;

  fact_ctrl #(.ITER_W(5)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Go     (Go),
    .GT12   (GT12),
    .GT1    (GT1),
    .Ld_CNT (Ld_CNT),
    .EN     (EN),
    .Sel    (Sel),
    .LdR    (LdR),
    .OE     (OE),
    .Done   (Done),
    .Error  (Error),
    .ITER   (ITER),
    .STATE  (STATE)
  );

  // Datapath model: counter, comparators, multiplier loop and output mux.
  assign GT12   = (n > 12);
  assign GT1    = (cnt_q > 32'd1);
  assign result = OE ? reg_q : 32'd0;

  always @(posedge CLK) begin
    if (EN)  cnt_q <= Ld_CNT ? n : cnt_q - 32'd1;
    if (LdR) reg_q <= Sel ? 32'd1 : reg_q * cnt_q;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, STATE, 0);
    chk({tag, "_ctl"}, {Ld_CNT, EN, Sel, LdR, OE, Done, Error}, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int   edges;
    bit   seen;
    int   bad;
    vec_t e;
    @(negedge CLK);
    n  = v.n;
    Go = 1'b1;
    sb_q.push_back(v);
    @(posedge CLK); #1;
    edges = 1;
    if (v.pulse) Go = 1'b0;
    chk("load_state", STATE, 1);
    chk("load_ctl", {Ld_CNT, EN, Sel, LdR, OE, Done, Error}, 7'b1111000);
    seen = 0;
    bad  = 0;
    while (!seen && edges < 60) begin
      @(posedge CLK); #1;
      edges++;
      if (STATE == 3'd3 && {Ld_CNT, EN, Sel, LdR, OE, Done, Error} != 7'b0101000) bad++;
      if (STATE == 3'd2 && {Ld_CNT, EN, Sel, LdR, OE, Done, Error} != 7'b0) bad++;
      if (Done || Error) seen = 1;
    end
    chk("ctl_violations", bad, 0);
    if (!seen) begin
      chk("timeout_done_or_error", 0, 1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk("latency", edges, e.exp_lat);
      chk("error", Error, e.exp_err);
      chk("done", Done, !e.exp_err);
      chk("oe", OE, !e.exp_err);
      chk("ldr_at_end", LdR, 0);
      chk("iter", ITER, e.exp_iter);
      if (!e.exp_err) chk("result", result, e.exp_result);
      chk("end_state", STATE, e.exp_err ? 5 : 4);
    end
    if (!v.pulse) begin
      repeat (2) @(posedge CLK);
      #1;
      chk("hold_state", STATE, v.exp_err ? 5 : 4);
      @(negedge CLK);
      Go = 1'b0;
      @(posedge CLK); #1;
    end else begin
      @(posedge CLK); #1;
    end
    chk_idle_outputs("back_idle");
    chk("iter_kept", ITER, v.exp_iter);
  endtask

  initial begin
    int waits;
    vecs[0] = '{n: 0,  pulse: 0, exp_err: 0, exp_iter: 0,  exp_result: 1,         exp_lat: 3};
    vecs[1] = '{n: 1,  pulse: 0, exp_err: 0, exp_iter: 0,  exp_result: 1,         exp_lat: 3};
    vecs[2] = '{n: 5,  pulse: 0, exp_err: 0, exp_iter: 4,  exp_result: 120,       exp_lat: 11};
    vecs[3] = '{n: 12, pulse: 0, exp_err: 0, exp_iter: 11, exp_result: 479001600, exp_lat: 25};
    vecs[4] = '{n: 13, pulse: 0, exp_err: 1, exp_iter: 0,  exp_result: 0,         exp_lat: 3};
    vecs[5] = '{n: 7,  pulse: 0, exp_err: 0, exp_iter: 6,  exp_result: 5040,      exp_lat: 15};
    vecs[6] = '{n: 3,  pulse: 1, exp_err: 0, exp_iter: 2,  exp_result: 6,         exp_lat: 7};

    #1;
    chk_idle_outputs("in_reset");
    chk("in_reset_iter", ITER, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Asynchronous reset in the middle of a multiply loop.
    @(negedge CLK);
    n  = 7;
    Go = 1'b1;
    waits = 0;
    do begin
      @(posedge CLK); #1;
      waits++;
    end while (!(STATE == 3'd3 && ITER >= 5'd1) && waits < 20);
    chk("reach_mult", STATE, 3);
    #2;
    RST = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_iter", ITER, 0);
    @(negedge CLK);
    Go  = 1'b0;
    RST = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    chk("scoreboard_empty", sb_q.size(), 0);

    // Unused state code falls back to IDLE with outputs low.
    @(negedge CLK);
    force dut.state_q = 3'd6;
    #1;
    chk("state6", STATE, 6);
    chk("state6_ctl", {Ld_CNT, EN, Sel, LdR, OE, Done, Error}, 0);
    release dut.state_q;
    @(posedge CLK); #1;
    chk_idle_outputs("from_state6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
